// File: rtl/pipe_hazard_if.sv
// Hazard-control bundle between the 5-stage pipeline datapath and its
// hazard controller. master = datapath side, slave = controller side.
interface pipe_hazard_if #(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] rs1_d, rs2_d;
  logic [REG_AW-1:0] rs1_e, rs2_e, rd_e;
  logic              resultsrc_e0, pcsrc_e, mc_start_e;
  logic [REG_AW-1:0] rd_m, rd_w;
  logic              regwrite_m, regwrite_w;
  logic              stall_f, stall_d, stall_e;
  logic              flush_d, flush_e, flush_m;
  logic [1:0]        forward_a_e, forward_b_e;
  logic              mc_busy;

  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, resultsrc_e0, pcsrc_e,
           mc_start_e, rd_m, regwrite_m, rd_w, regwrite_w,
    input  stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
           forward_a_e, forward_b_e, mc_busy
  );

  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, resultsrc_e0, pcsrc_e,
           mc_start_e, rd_m, regwrite_m, rd_w, regwrite_w,
    output stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
           forward_a_e, forward_b_e, mc_busy
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: EX forwarding
// selects, load-use stall, branch flush and a hold FSM for multi-cycle
// EX ops. Everything is combinational except the FSM state and counter.
module pipe_hazard_ctrl #(
  parameter int MC_LAT = 4,   // cycles an mc op spends in EX, 2..16
  parameter int REG_AW = 5
) (
  input  logic         clk,
  input  logic         reset,
  pipe_hazard_if.slave hz
);

  localparam logic [REG_AW-1:0] X0     = '0;
  localparam logic [3:0]        CNT_LD = 4'(MC_LAT - 2);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       mc_stall, lwstall;

  // MEM result beats WB result; x0 is never forwarded
  function automatic logic [1:0] fwd_sel(
    input logic [REG_AW-1:0] rs,
    input logic [REG_AW-1:0] rd_m, input logic we_m,
    input logic [REG_AW-1:0] rd_w, input logic we_w
  );
    if (we_m && rd_m != X0 && rd_m == rs)      return 2'b10;
    else if (we_w && rd_w != X0 && rd_w == rs) return 2'b01;
    else                                       return 2'b00;
  endfunction

  // FSM state and countdown register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // FSM next state: hold id_ex until the mc op has been in EX MC_LAT cycles
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mc_stall  = 1'b0;
    case (state)
      IDLE: if (hz.mc_start_e) begin
        mc_stall  = 1'b1;
        state_nxt = BUSY;
        cnt_nxt   = CNT_LD;
      end
      BUSY: if (cnt != 4'd0) begin
        mc_stall = 1'b1;
        cnt_nxt  = cnt - 4'd1;
      end else begin
        state_nxt = IDLE;   // release cycle: id_ex advances on this edge
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign lwstall = hz.resultsrc_e0 && hz.rd_e != X0 &&
                   (hz.rd_e == hz.rs1_d || hz.rd_e == hz.rs2_d);

  assign hz.mc_busy = (state == BUSY);

  // Pipeline controls; reset forces bubbles everywhere and no stalls
  always_comb begin
    hz.stall_f     = 1'b0;
    hz.stall_d     = 1'b0;
    hz.stall_e     = 1'b0;
    hz.flush_d     = 1'b1;
    hz.flush_e     = 1'b1;
    hz.flush_m     = 1'b1;
    hz.forward_a_e = 2'b00;
    hz.forward_b_e = 2'b00;
    if (!reset) begin
      hz.stall_f     = lwstall | mc_stall;
      hz.stall_d     = lwstall | mc_stall;
      hz.stall_e     = mc_stall;
      hz.flush_m     = mc_stall;
      hz.flush_d     = hz.pcsrc_e;
      // a held id_ex must never be cleared
      hz.flush_e     = (lwstall | hz.pcsrc_e) & ~mc_stall;
      hz.forward_a_e = fwd_sel(hz.rs1_e, hz.rd_m, hz.regwrite_m,
                               hz.rd_w, hz.regwrite_w);
      hz.forward_b_e = fwd_sel(hz.rs2_e, hz.rd_m, hz.regwrite_m,
                               hz.rd_w, hz.regwrite_w);
    end
  end

endmodule
